// File: rtl/mem_rd_arbiter.sv
// Arbitrates the shared memory read port between I-cache and D-cache refill bursts.
// One requester owns the port from request acceptance until its last beat is taken.
module mem_rd_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter bit DC_PRIORITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  from_ic_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_ic_rd_req_addr,
  output logic                  to_ic_rd_req_ready,
  output logic                  to_ic_rd_rsp_valid,
  output logic [31:0]           to_ic_rd_rsp_data,
  output logic                  to_ic_rd_rsp_last,
  input  logic                  from_ic_rd_rsp_ready,
  input  logic                  from_dc_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_dc_rd_req_addr,
  output logic                  to_dc_rd_req_ready,
  output logic                  to_dc_rd_rsp_valid,
  output logic [31:0]           to_dc_rd_rsp_data,
  output logic                  to_dc_rd_rsp_last,
  input  logic                  from_dc_rd_rsp_ready,
  output logic                  to_mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
  input  logic                  from_mem_rd_req_ready,
  input  logic                  from_mem_rd_rsp_valid,
  input  logic [31:0]           from_mem_rd_rsp_data,
  input  logic                  from_mem_rd_rsp_last,
  output logic                  to_mem_rd_rsp_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic       OWN_IC  = 1'b0;
  localparam logic       OWN_DC  = 1'b1;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  last_grant_q, last_grant_d;

  logic pick_dc_s;
  logic owner_rsp_ready_s;
  logic in_req_s;
  logic in_rsp_s;

  // Winner selection; a lone requester always wins, ties go by mode.
  always_comb begin
    if (DC_PRIORITY) begin
      pick_dc_s = from_dc_rd_req_valid;
    end else begin
      pick_dc_s = from_dc_rd_req_valid &&
                  (!from_ic_rd_req_valid || (last_grant_q == OWN_IC));
    end
  end

  assign owner_rsp_ready_s = (owner_q == OWN_DC) ? from_dc_rd_rsp_ready : from_ic_rd_rsp_ready;

  // Next-state logic for the burst FSM and its bookkeeping registers.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (from_ic_rd_req_valid || from_dc_rd_req_valid) begin
          owner_d = pick_dc_s ? OWN_DC : OWN_IC;
          addr_d  = pick_dc_s ? from_dc_rd_req_addr : from_ic_rd_req_addr;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (from_mem_rd_req_ready) begin
          last_grant_d = owner_q;
          state_d      = ST_RSP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RSP: begin
        if (from_mem_rd_rsp_valid && owner_rsp_ready_s && from_mem_rd_rsp_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; last_grant starts at DC so IC wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IC;
      addr_q       <= '0;
      last_grant_q <= OWN_DC;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Gating on rst forces every output low during the reset cycle itself.
  assign in_req_s = (state_q == ST_REQ) && !rst;
  assign in_rsp_s = (state_q == ST_RSP) && !rst;

  // Output steering toward the current owner; everything else stays low.
  always_comb begin
    to_mem_rd_req_valid = in_req_s;
    to_mem_rd_req_addr  = in_req_s ? addr_q : '0;
    to_ic_rd_req_ready  = in_req_s && (owner_q == OWN_IC) && from_mem_rd_req_ready;
    to_dc_rd_req_ready  = in_req_s && (owner_q == OWN_DC) && from_mem_rd_req_ready;
    to_mem_rd_rsp_ready = in_rsp_s && owner_rsp_ready_s;
    to_ic_rd_rsp_valid  = 1'b0;
    to_ic_rd_rsp_data   = 32'h0;
    to_ic_rd_rsp_last   = 1'b0;
    to_dc_rd_rsp_valid  = 1'b0;
    to_dc_rd_rsp_data   = 32'h0;
    to_dc_rd_rsp_last   = 1'b0;
    if (in_rsp_s && (owner_q == OWN_IC)) begin
      to_ic_rd_rsp_valid = from_mem_rd_rsp_valid;
      to_ic_rd_rsp_data  = from_mem_rd_rsp_data;
      to_ic_rd_rsp_last  = from_mem_rd_rsp_last;
    end else if (in_rsp_s && (owner_q == OWN_DC)) begin
      to_dc_rd_rsp_valid = from_mem_rd_rsp_valid;
      to_dc_rd_rsp_data  = from_mem_rd_rsp_data;
      to_dc_rd_rsp_last  = from_mem_rd_rsp_last;
    end else begin
      to_ic_rd_rsp_valid = 1'b0;
      to_dc_rd_rsp_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: one round-robin and one DC-priority instance share stimulus;
// the bench plays both caches and the memory side, checking the instance selected by use_pr.
module tb_mem_rd_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ic_valid, dc_valid, ic_rsp_ready, dc_rsp_ready;
  logic [31:0] ic_addr, dc_addr;
  logic        mem_req_ready, mem_rsp_valid, mem_rsp_last;
  logic [31:0] mem_rsp_data;
  logic        use_pr;

  int errors = 0;
  int checks = 0;

  logic        rr_ic_req_ready, rr_ic_rsp_valid, rr_ic_rsp_last;
  logic        rr_dc_req_ready, rr_dc_rsp_valid, rr_dc_rsp_last;
  logic [31:0] rr_ic_rsp_data, rr_dc_rsp_data, rr_mem_req_addr;
  logic        rr_mem_req_valid, rr_mem_rsp_ready;
  logic        pr_ic_req_ready, pr_ic_rsp_valid, pr_ic_rsp_last;
  logic        pr_dc_req_ready, pr_dc_rsp_valid, pr_dc_rsp_last;
  logic [31:0] pr_ic_rsp_data, pr_dc_rsp_data, pr_mem_req_addr;
  logic        pr_mem_req_valid, pr_mem_rsp_ready;

  mem_rd_arbiter #(.ADDR_WIDTH(32), .DC_PRIORITY(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .from_ic_rd_req_valid(ic_valid), .from_ic_rd_req_addr(ic_addr),
    .to_ic_rd_req_ready(rr_ic_req_ready), .to_ic_rd_rsp_valid(rr_ic_rsp_valid),
    .to_ic_rd_rsp_data(rr_ic_rsp_data), .to_ic_rd_rsp_last(rr_ic_rsp_last),
    .from_ic_rd_rsp_ready(ic_rsp_ready),
    .from_dc_rd_req_valid(dc_valid), .from_dc_rd_req_addr(dc_addr),
    .to_dc_rd_req_ready(rr_dc_req_ready), .to_dc_rd_rsp_valid(rr_dc_rsp_valid),
    .to_dc_rd_rsp_data(rr_dc_rsp_data), .to_dc_rd_rsp_last(rr_dc_rsp_last),
    .from_dc_rd_rsp_ready(dc_rsp_ready),
    .to_mem_rd_req_valid(rr_mem_req_valid), .to_mem_rd_req_addr(rr_mem_req_addr),
    .from_mem_rd_req_ready(mem_req_ready), .from_mem_rd_rsp_valid(mem_rsp_valid),
    .from_mem_rd_rsp_data(mem_rsp_data), .from_mem_rd_rsp_last(mem_rsp_last),
    .to_mem_rd_rsp_ready(rr_mem_rsp_ready)
  );

  mem_rd_arbiter #(.ADDR_WIDTH(32), .DC_PRIORITY(1'b1)) u_pr (
    .clk(clk), .rst(rst),
    .from_ic_rd_req_valid(ic_valid), .from_ic_rd_req_addr(ic_addr),
    .to_ic_rd_req_ready(pr_ic_req_ready), .to_ic_rd_rsp_valid(pr_ic_rsp_valid),
    .to_ic_rd_rsp_data(pr_ic_rsp_data), .to_ic_rd_rsp_last(pr_ic_rsp_last),
    .from_ic_rd_rsp_ready(ic_rsp_ready),
    .from_dc_rd_req_valid(dc_valid), .from_dc_rd_req_addr(dc_addr),
    .to_dc_rd_req_ready(pr_dc_req_ready), .to_dc_rd_rsp_valid(pr_dc_rsp_valid),
    .to_dc_rd_rsp_data(pr_dc_rsp_data), .to_dc_rd_rsp_last(pr_dc_rsp_last),
    .from_dc_rd_rsp_ready(dc_rsp_ready),
    .to_mem_rd_req_valid(pr_mem_req_valid), .to_mem_rd_req_addr(pr_mem_req_addr),
    .from_mem_rd_req_ready(mem_req_ready), .from_mem_rd_rsp_valid(mem_rsp_valid),
    .from_mem_rd_rsp_data(mem_rsp_data), .from_mem_rd_rsp_last(mem_rsp_last),
    .to_mem_rd_rsp_ready(pr_mem_rsp_ready)
  );

  wire        o_ic_req_ready  = use_pr ? pr_ic_req_ready  : rr_ic_req_ready;
  wire        o_ic_rsp_valid  = use_pr ? pr_ic_rsp_valid  : rr_ic_rsp_valid;
  wire        o_ic_rsp_last   = use_pr ? pr_ic_rsp_last   : rr_ic_rsp_last;
  wire [31:0] o_ic_rsp_data   = use_pr ? pr_ic_rsp_data   : rr_ic_rsp_data;
  wire        o_dc_req_ready  = use_pr ? pr_dc_req_ready  : rr_dc_req_ready;
  wire        o_dc_rsp_valid  = use_pr ? pr_dc_rsp_valid  : rr_dc_rsp_valid;
  wire        o_dc_rsp_last   = use_pr ? pr_dc_rsp_last   : rr_dc_rsp_last;
  wire [31:0] o_dc_rsp_data   = use_pr ? pr_dc_rsp_data   : rr_dc_rsp_data;
  wire        o_mem_req_valid = use_pr ? pr_mem_req_valid : rr_mem_req_valid;
  wire [31:0] o_mem_req_addr  = use_pr ? pr_mem_req_addr  : rr_mem_req_addr;
  wire        o_mem_rsp_ready = use_pr ? pr_mem_rsp_ready : rr_mem_rsp_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, o_ic_rsp_data | o_dc_rsp_data | o_mem_req_addr |
             {24'd0, o_ic_req_ready, o_ic_rsp_valid, o_ic_rsp_last, o_dc_req_ready,
              o_dc_rsp_valid, o_dc_rsp_last, o_mem_req_valid, o_mem_rsp_ready}, 32'd0);
  endtask

  // Called just after a negedge while the DUT is IDLE with the request(s) already driven.
  task automatic grant(input logic dc, input logic [31:0] a, input int delay, input bit drop);
    #1;
    chk("idle_req_valid", {31'd0, o_mem_req_valid}, 32'd0);
    chk("idle_req_ready", {30'd0, o_ic_req_ready, o_dc_req_ready}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < delay; i++) begin
      mem_req_ready = 1'b0;
      #1;
      chk("wait_req_valid", {31'd0, o_mem_req_valid}, 32'd1);
      chk("wait_req_addr", o_mem_req_addr, a);
      chk("wait_req_ready", {30'd0, o_ic_req_ready, o_dc_req_ready}, 32'd0);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    #1;
    chk("req_valid", {31'd0, o_mem_req_valid}, 32'd1);
    chk("req_addr", o_mem_req_addr, a);
    chk("req_ready_ic", {31'd0, o_ic_req_ready}, {31'd0, !dc});
    chk("req_ready_dc", {31'd0, o_dc_req_ready}, {31'd0, dc});
    @(negedge clk);
    mem_req_ready = 1'b0;
    if (drop) begin
      if (dc) dc_valid = 1'b0;
      else    ic_valid = 1'b0;
    end
    #1;
    chk("rsp_no_req_valid", {31'd0, o_mem_req_valid}, 32'd0);
    chk("req_ready_once", {30'd0, o_ic_req_ready, o_dc_req_ready}, 32'd0);
  endtask

  // Plays an 8-beat burst; the owner withholds ready for stall_len cycles at beat stall_at.
  task automatic burst(input logic dc, input logic [31:0] base, input int stall_at,
                       input int stall_len, input int stop_at);
    int   idx = 0;
    int   stalled = 0;
    int   got = 0;
    int   cyc = 0;
    logic rdy;
    while (idx < stop_at && cyc < 64) begin
      rdy           = !(idx == stall_at && stalled < stall_len);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = base + 32'(idx);
      mem_rsp_last  = (idx == 7);
      ic_rsp_ready  = dc ? 1'b1 : rdy;
      dc_rsp_ready  = dc ? rdy : 1'b1;
      #1;
      chk("beat_valid", {31'd0, dc ? o_dc_rsp_valid : o_ic_rsp_valid}, 32'd1);
      chk("beat_data", dc ? o_dc_rsp_data : o_ic_rsp_data, base + 32'(idx));
      chk("beat_last", {31'd0, dc ? o_dc_rsp_last : o_ic_rsp_last}, {31'd0, idx == 7});
      chk("other_valid", {30'd0, dc ? o_ic_rsp_valid : o_dc_rsp_valid,
                                 dc ? o_ic_rsp_last  : o_dc_rsp_last}, 32'd0);
      chk("other_data", dc ? o_ic_rsp_data : o_dc_rsp_data, 32'd0);
      chk("mem_rsp_ready", {31'd0, o_mem_rsp_ready}, {31'd0, rdy});
      if ((dc ? o_dc_rsp_valid : o_ic_rsp_valid) && o_mem_rsp_ready) got++;
      @(negedge clk);
      if (rdy) idx++;
      else     stalled++;
      cyc++;
    end
    if (stop_at == 8) begin
      mem_rsp_valid = 1'b0;
      mem_rsp_last  = 1'b0;
      mem_rsp_data  = 32'h0;
    end
    chk("beat_count", 32'(got), 32'(stop_at));
  endtask

  initial begin
    rst = 1'b1; use_pr = 1'b0;
    ic_valid = 1'b0; dc_valid = 1'b0; ic_addr = 32'h0; dc_addr = 32'h0;
    ic_rsp_ready = 1'b0; dc_rsp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0; mem_rsp_data = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset_rr");
    use_pr = 1'b1;
    #1;
    chk_zero("reset_pr");
    use_pr = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // IC only at 0x1040, beats A0..A7
    ic_valid = 1'b1; ic_addr = 32'h0000_1040;
    grant(1'b0, 32'h0000_1040, 0, 1'b1);
    burst(1'b0, 32'hA0, 99, 0, 8);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55;
    #1;
    chk("stray_rsp_ready", {31'd0, o_mem_rsp_ready}, 32'd0);
    chk("stray_ic_valid", {31'd0, o_ic_rsp_valid}, 32'd0);
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    @(negedge clk);

    // Round-robin ties: IC, then DC (with a 3-cycle stall), then IC again
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ic_valid = 1'b1; ic_addr = 32'h0000_2000;
    dc_valid = 1'b1; dc_addr = 32'h0000_3020;
    grant(1'b0, 32'h0000_2000, 0, 1'b1);
    burst(1'b0, 32'hB0, 99, 0, 8);
    grant(1'b1, 32'h0000_3020, 0, 1'b1);
    burst(1'b1, 32'hC0, 3, 3, 8);
    ic_valid = 1'b1; ic_addr = 32'h0000_4000;
    dc_valid = 1'b1; dc_addr = 32'h0000_5000;
    grant(1'b0, 32'h0000_4000, 0, 1'b1);
    burst(1'b0, 32'hD0, 99, 0, 8);
    grant(1'b1, 32'h0000_5000, 0, 1'b1);
    burst(1'b1, 32'hE0, 99, 0, 8);

    // Memory request ready held off 5 cycles
    ic_valid = 1'b1; ic_addr = 32'h0000_6060;
    grant(1'b0, 32'h0000_6060, 5, 1'b1);
    burst(1'b0, 32'h10, 99, 0, 8);

    // DC priority: DC holds valid for 3 bursts, IC waits until DC drops
    use_pr = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ic_valid = 1'b1; ic_addr = 32'h0000_7000;
    dc_valid = 1'b1; dc_addr = 32'h0000_8000;
    grant(1'b1, 32'h0000_8000, 0, 1'b0);
    burst(1'b1, 32'h20, 99, 0, 8);
    grant(1'b1, 32'h0000_8000, 0, 1'b0);
    burst(1'b1, 32'h30, 99, 0, 8);
    grant(1'b1, 32'h0000_8000, 0, 1'b1);
    burst(1'b1, 32'h40, 99, 0, 8);
    grant(1'b0, 32'h0000_7000, 0, 1'b1);
    burst(1'b0, 32'h50, 99, 0, 8);

    // Reset after beat 4 of an IC burst, then a DC burst
    use_pr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ic_valid = 1'b1; ic_addr = 32'h0000_9000;
    grant(1'b0, 32'h0000_9000, 0, 1'b1);
    burst(1'b0, 32'hA0, 99, 0, 4);
    rst = 1'b1;
    #1;
    chk_zero("in_reset_zero");
    @(negedge clk);
    #1;
    chk_zero("post_reset_zero");
    rst = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0; mem_rsp_data = 32'h0;
    ic_rsp_ready = 1'b0; dc_rsp_ready = 1'b0;
    #1;
    chk_zero("idle_after_reset");
    dc_valid = 1'b1; dc_addr = 32'h0000_A0E0;
    grant(1'b1, 32'h0000_A0E0, 0, 1'b1);
    burst(1'b1, 32'h60, 99, 0, 8);
    #1;
    chk_zero("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
